// File: rtl/wave_gen_pkg.sv
// rtl/wave_gen_pkg.sv - shared state encoding, frame sizing and duty conversion for wave output stages
package wave_gen_pkg;

  localparam int DEFAULT_N_FRAC = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } pwm_state_t;

  // Last counter value of a PWM frame; the frame is 2^(n_frac+1) cycles long.
  function automatic logic [31:0] frame_max(input int n_frac);
    return (32'd1 << (n_frac + 1)) - 32'd1;
  endfunction

  // Signed sample to offset-binary duty: flipping the sign bit maps -2^n_frac to 0
  // and 2^n_frac-1 to full scale, so no saturation is ever needed.
  function automatic logic [31:0] offset_duty(input logic [31:0] s, input int n_frac);
    logic [31:0] mask;
    mask = frame_max(n_frac);
    return (s & mask) ^ (32'd1 << n_frac);
  endfunction

endpackage

// File: rtl/pwm_frame_counter.sv
// rtl/pwm_frame_counter.sv - clearable frame counter with registered duty compare and wrap flag
module pwm_frame_counter
  import wave_gen_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear_i,
  input  logic         run_i,
  input  logic [W-1:0] duty_i,
  output logic [W-1:0] cnt_o,
  output logic         pwm_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] CNT_MAX = W'(frame_max(W - 1));

  // Count through the frame (natural wrap at MAX) and register the duty compare.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
      pwm_o <= 1'b0;
    end else begin
      pwm_o <= run_i && (cnt_o < duty_i);
      if (clear_i) begin
        cnt_o <= '0;
      end else begin
        cnt_o <= cnt_o + 1'b1;
      end
    end
  end

  assign wrap_o = (cnt_o == CNT_MAX);

endmodule

// File: rtl/pwm_output_stage.sv
// rtl/pwm_output_stage.sv - paces sample requests per PWM frame and plays samples out as PWM
module pwm_output_stage
  import wave_gen_pkg::*;
#(
  parameter int N_FRAC = DEFAULT_N_FRAC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic signed [N_FRAC:0] data_i,
  input  logic                data_valid_strobe_i,
  output logic                next_data_strobe_o,
  output logic                pwm_o,
  output logic signed [N_FRAC:0] sample_o,
  output logic                underrun_strobe_o
);

  localparam int SW = N_FRAC + 1;

  pwm_state_t              state;
  pwm_state_t              state_nxt;
  logic signed [SW-1:0]    active;
  logic signed [SW-1:0]    pending;
  logic [SW-1:0]           cnt;
  logic [SW-1:0]           duty;
  logic                    wrap;
  logic                    run;
  logic                    clear;

  assign duty  = SW'(offset_duty(32'(active), N_FRAC));
  assign run   = (state != ST_IDLE);
  assign clear = (state == ST_IDLE) || !enable_i;

  pwm_frame_counter #(
    .W(SW)
  ) u_counter (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(clear),
    .run_i  (run),
    .duty_i (duty),
    .cnt_o  (cnt),
    .pwm_o  (pwm_o),
    .wrap_o (wrap)
  );

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and Moore/Mealy strobes; dropping enable overrides everything.
  always_comb begin
    state_nxt          = state;
    next_data_strobe_o = (state == ST_REQ);
    underrun_strobe_o  = 1'b0;
    case (state)
      ST_IDLE: if (enable_i) state_nxt = ST_REQ;
      ST_REQ:  state_nxt = data_valid_strobe_i ? ST_HOLD : ST_WAIT;
      ST_WAIT: begin
        if (wrap) begin
          state_nxt         = ST_REQ;
          underrun_strobe_o = enable_i && !data_valid_strobe_i;
        end else if (data_valid_strobe_i) begin
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: if (wrap) state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable_i) state_nxt = ST_IDLE;
  end

  // Sample capture into pending, promotion to active at frame end; a late
  // capture on the last cycle goes straight to active.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending <= '0;
      active  <= '0;
    end else if (!enable_i) begin
      pending <= '0;
      active  <= '0;
    end else begin
      case (state)
        ST_REQ: if (data_valid_strobe_i) pending <= data_i;
        ST_WAIT: begin
          if (data_valid_strobe_i) pending <= data_i;
          if (wrap && data_valid_strobe_i) active <= data_i;
        end
        ST_HOLD: if (wrap) active <= pending;
        default: ;
      endcase
    end
  end

  assign sample_o = active;

endmodule

// File: tb/tb_pwm_output_stage.sv
// tb/tb_pwm_output_stage.sv - scoreboard bench for pwm_output_stage
module tb_pwm_output_stage;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              enable_i = 1'b0;
  logic signed [7:0] data_i = '0;
  logic              data_valid_strobe_i = 1'b0;
  logic              next_data_strobe_o;
  logic              pwm_o;
  logic signed [7:0] sample_o;
  logic              underrun_strobe_o;

  int checks = 0;
  int fails  = 0;

  int                exp_duty_q[$];
  logic signed [7:0] exp_samp_q[$];
  logic signed [7:0] model_active;

  pwm_output_stage #(.N_FRAC(7)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .data_i             (data_i),
    .data_valid_strobe_i(data_valid_strobe_i),
    .next_data_strobe_o (next_data_strobe_o),
    .pwm_o              (pwm_o),
    .sample_o           (sample_o),
    .underrun_strobe_o  (underrun_strobe_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int duty_model(input logic signed [7:0] v);
    return int'(v) + 128;
  endfunction

  task automatic wait_request;
    int n;
    n = 0;
    while (!next_data_strobe_o && n < 300) begin
      tick;
      n++;
    end
    check("request_seen", 32'(next_data_strobe_o), 32'd1);
  endtask

  // One full frame: optional responses at given offsets from the request cycle.
  task automatic run_frame(input bit resp, input int off, input logic signed [7:0] val,
                           input bit resp2, input int off2, input logic signed [7:0] val2);
    int                hi, und, und_at, mid_req, exp_hi;
    logic signed [7:0] exp_s;
    exp_hi = exp_duty_q.pop_front();
    exp_s  = exp_samp_q.pop_front();
    if (resp) model_active = val;
    exp_duty_q.push_back(duty_model(model_active));
    exp_samp_q.push_back(model_active);
    wait_request;
    check("sample_at_frame_start", 32'(sample_o), 32'(exp_s));
    hi = 0; und = 0; und_at = -1; mid_req = 0;
    for (int k = 0; k < 256; k++) begin
      data_valid_strobe_i = (resp && k == off) || (resp2 && k == off2);
      data_i = (resp2 && k == off2) ? val2 : val;
      #1;
      if (underrun_strobe_o) begin
        und++;
        und_at = k;
      end
      tick;
      data_valid_strobe_i = 1'b0;
      if (pwm_o) hi++;
      if (k < 255 && next_data_strobe_o) mid_req++;
    end
    check("pwm_high_cycles", 32'(hi), 32'(exp_hi));
    check("no_mid_frame_request", 32'(mid_req), 32'd0);
    check("request_at_frame_end", 32'(next_data_strobe_o), 32'd1);
    check("underrun_pulses", 32'(und), resp ? 32'd0 : 32'd1);
    if (!resp) check("underrun_cycle", 32'(und_at), 32'd255);
  endtask

  initial begin
    int                exp_hi;
    logic signed [7:0] exp_s;

    // Reset state
    tick; tick;
    check("reset_pwm", 32'(pwm_o), 32'd0);
    check("reset_req", 32'(next_data_strobe_o), 32'd0);
    check("reset_underrun", 32'(underrun_strobe_o), 32'd0);
    check("reset_sample", 32'(sample_o), 32'd0);
    rst_i = 1'b1;
    tick;

    // Enable: first request one cycle later, first frame at midscale
    enable_i = 1'b1;
    check("idle_no_req", 32'(next_data_strobe_o), 32'd0);
    tick;
    check("first_req", 32'(next_data_strobe_o), 32'd1);

    model_active = 8'd0;
    exp_duty_q.push_back(128);
    exp_samp_q.push_back(8'd0);

    run_frame(1'b1, 3, 8'd127, 1'b0, 0, 8'd0);
    run_frame(1'b1, 3, 8'h80, 1'b0, 0, 8'd0);
    run_frame(1'b1, 3, 8'd0, 1'b0, 0, 8'd0);
    run_frame(1'b0, 0, 8'd0, 1'b0, 0, 8'd0);
    run_frame(1'b1, 255, 8'd64, 1'b0, 0, 8'd0);
    run_frame(1'b1, 3, 8'd100, 1'b1, 10, 8'hC0);
    run_frame(1'b0, 0, 8'd0, 1'b0, 0, 8'd0);

    // Drop enable mid-frame while pwm is high
    exp_hi = exp_duty_q.pop_front();
    exp_s  = exp_samp_q.pop_front();
    wait_request;
    check("sample_before_drop", 32'(sample_o), 32'(exp_s));
    for (int k = 0; k < 50; k++) tick;
    check("pwm_high_before_drop", 32'(pwm_o), (50 <= exp_hi) ? 32'd1 : 32'd0);
    enable_i = 1'b0;
    tick;
    check("drop_sample_midscale", 32'(sample_o), 32'd0);
    check("drop_no_req", 32'(next_data_strobe_o), 32'd0);
    data_valid_strobe_i = 1'b1;
    data_i = 8'd50;
    tick;
    data_valid_strobe_i = 1'b0;
    check("drop_pwm_low", 32'(pwm_o), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick;
      check("idle_pwm_low", 32'(pwm_o), 32'd0);
    end
    check("idle_sample", 32'(sample_o), 32'd0);

    // Re-enable: requests restart, late strobe left no trace
    enable_i = 1'b1;
    check("reenable_idle_no_req", 32'(next_data_strobe_o), 32'd0);
    tick;
    check("reenable_req", 32'(next_data_strobe_o), 32'd1);
    exp_duty_q.delete();
    exp_samp_q.delete();
    model_active = 8'd0;
    exp_duty_q.push_back(128);
    exp_samp_q.push_back(8'd0);
    run_frame(1'b1, 3, 8'd127, 1'b0, 0, 8'd0);

    // Asynchronous reset at cnt = 100 with pwm high
    exp_hi = exp_duty_q.pop_front();
    exp_s  = exp_samp_q.pop_front();
    wait_request;
    check("sample_full_scale", 32'(sample_o), 32'(exp_s));
    for (int k = 0; k < 100; k++) tick;
    check("pwm_high_at_100", 32'(pwm_o), (100 <= exp_hi) ? 32'd1 : 32'd0);
    rst_i = 1'b0;
    #1;
    check("async_reset_pwm", 32'(pwm_o), 32'd0);
    check("async_reset_sample", 32'(sample_o), 32'd0);
    check("async_reset_req", 32'(next_data_strobe_o), 32'd0);
    check("async_reset_underrun", 32'(underrun_strobe_o), 32'd0);
    enable_i = 1'b0;
    tick;
    rst_i = 1'b1;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/pwm_output_stage.md
# pwm_output_stage

Downstream consumer of the sine generator: paces sample requests at a fixed PWM frame rate, captures each returned signed sample, and plays it out as a single-bit PWM stream for an external RC filter. It drives the generator's next-data strobe input and consumes its data and valid-strobe outputs, closing the request/response loop to the chip pin.

## Interface
- N_FRAC, 7: fractional bits. Sample width is N_FRAC+1 (signed); PWM frame is 2^(N_FRAC+1) cycles.
- clk_i  in  1  system clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  run request; low forces IDLE.
- data_i  in  N_FRAC+1  signed sample from the sine generator.
- data_valid_strobe_i  in  1  one-cycle pulse qualifying data_i.
- next_data_strobe_o  out  1  one-cycle request for the next sample.
- pwm_o  out  1  registered PWM output.
- sample_o  out  N_FRAC+1  signed sample currently being played (active register).
- underrun_strobe_o  out  1  one-cycle pulse when a frame ends with no new sample.

## Operation
- Duty mapping: duty = {~s[N_FRAC], s[N_FRAC-1:0]} (offset binary). -2^N_FRAC maps to duty 0, 0 maps to 2^N_FRAC, 2^N_FRAC-1 maps to 2^(N_FRAC+1)-1. No saturation is needed.
- Frame counter cnt is N_FRAC+1 bits, wraps at MAX = 2^(N_FRAC+1)-1.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: cnt = 0. If enable_i = 1, go to REQ.
  - REQ: next_data_strobe_o = 1 (Moore). cnt = 0 and increments. Go to WAIT, or HOLD if data_valid_strobe_i is also asserted (capture it).
  - WAIT: on data_valid_strobe_i, pending <= data_i; go to HOLD.
  - HOLD: further valid strobes are ignored.
  - Frame end, cnt = MAX, in WAIT or HOLD: cnt -> 0 and next state is REQ.
    - From HOLD: active <= pending.
    - From WAIT: active is unchanged and underrun_strobe_o pulses in that cycle.
    - A valid strobe arriving in WAIT on the cnt = MAX cycle is captured and loaded into active in that same update (no underrun).
- enable_i low in any non-IDLE state: next cycle the FSM is IDLE, cnt = 0, active = 0 (midscale), pending = 0. A request already issued is abandoned; a late valid strobe is ignored.
- First frame after enable plays active = 0 (50 % duty).

## Timing
- Reset values: pwm_o 0, next_data_strobe_o 0, underrun_strobe_o 0, sample_o 0, state IDLE, cnt 0, pending 0.
- next_data_strobe_o: exactly one pulse per frame, in the cycle where cnt = 0. The first pulse comes one cycle after enable_i is sampled high.
- pwm_o(t+1) = (state(t) != IDLE) && (cnt(t) < duty(active(t))). This gives one cycle of latency, and pwm_o = 0 the cycle after entering IDLE.
- Upstream latency budget: a sample is accepted if it arrives within cycles 0..MAX of the frame. Its value is heard in the following frame, so request-to-audible latency is 2^(N_FRAC+1)+1 cycles.
- sample_o updates on the cycle after cnt = MAX, i.e. together with cnt returning to 0.
- Reset is asynchronous, and deassertion is used as-is: the integration provides the synchronizer. Reset mid-frame returns all outputs to their reset values immediately.

## Structure
- Shared package wave_gen_pkg:
  - FSM state encoding localparams (2 bits).
  - the frame-length/MAX derivation.
  - the offset-binary duty conversion function, reusable by other output stages.
- One sub-module, pwm_frame_counter: the enabled, clearable cnt with a registered-compare pwm output and a wrap flag.
- The FSM, the pending/active registers and the strobes stay in the top module.

## Test plan
All scenarios use N_FRAC = 7 (frame = 256 cycles).
- Reset, then enable_i = 1 -> next_data_strobe_o pulses one cycle later, then every 256 cycles. The first frame has pwm_o high for exactly 128 cycles.
- Respond 3 cycles after each request with 127, -128, 0 -> the following frames carry 255, 0 and 128 high cycles respectively. sample_o changes at each frame boundary.
- No response to a request -> underrun_strobe_o pulses on the cnt = 255 cycle, and the next frame repeats the previous duty.
- Valid strobe exactly on the cnt = 255 cycle with 64 -> no underrun, and the next frame has 192 high cycles. A second strobe in HOLD with -64 is ignored.
- enable_i dropped mid-frame, a late valid strobe, then re-enable -> pwm_o is 0 the next cycle, sample_o = 0, the strobe is ignored, and requests restart one cycle after re-enable.
- rst_i asserted at cnt = 100 with pwm_o high -> all outputs go to 0 without waiting for a clock edge.
